// File: rtl/even_issue_ctrl.sv
// Issue/hazard controller for the even pipe. It keeps a shadow scoreboard of in-flight ops, selects
// operand forwarding for the issuing op, and inserts bubbles until every source can be forwarded.
module even_issue_ctrl #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 7,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:7]        in_cse,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [ADDR_W-1:0] in_src_a,
    input  logic [ADDR_W-1:0] in_src_b,
    input  logic [ADDR_W-1:0] in_src_c,
    input  logic              in_use_a,
    input  logic              in_use_b,
    input  logic              in_use_c,
    output logic [0:7]        out_cse,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        fwd_a,
    output logic [3:0]        fwd_b,
    output logic [3:0]        fwd_c,
    output logic              hazard,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned FWD_W = 4;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] CLS_BYTE = 2'b00;
    localparam logic [1:0] CLS_FX1  = 2'b01;
    localparam logic [1:0] CLS_FX2  = 2'b10;
    localparam logic [1:0] CLS_FP   = 2'b11;

    typedef struct packed {
        logic              wee;
        logic [ADDR_W-1:0] dest;
        logic [1:0]        cls;
    } shadow_t;

    typedef struct packed {
        logic             not_ready;
        logic [FWD_W-1:0] code;
    } fwd_t;

    shadow_t [DEPTH-1:0] stage_q;   // index 0 is S1 (youngest)
    shadow_t             s1_d;
    fwd_t                res_a;
    fwd_t                res_b;
    fwd_t                res_c;
    logic                issue;

    // Forward code (or not-ready) for a producer of class cls sitting in stage k (1-based).
    function automatic fwd_t stage_code(input logic [1:0] cls, input int unsigned k);
        fwd_t r;
        r = '0;
        case (cls)
            CLS_FX1: begin
                if (k < 2)       r.not_ready = 1'b1;
                else if (k == 2) r.code = 4'd1;
                else if (k <= 7) r.code = FWD_W'(k - 1);
            end
            CLS_BYTE, CLS_FX2: begin
                if (k < 4)       r.not_ready = 1'b1;
                else if (k == 4) r.code = (cls == CLS_BYTE) ? 4'd8 : 4'd7;
                else if (k <= 7) r.code = FWD_W'(k - 1);
            end
            CLS_FP: begin
                if (k < 6)       r.not_ready = 1'b1;
                else if (k <= 7) r.code = 4'd9;
            end
        endcase
        return r;
    endfunction

    // Youngest matching producer decides; older matches are shadowed.
    function automatic fwd_t lookup(input logic              use_src,
                                    input logic [ADDR_W-1:0] src,
                                    input shadow_t [DEPTH-1:0] st);
        fwd_t r;
        logic found;
        r     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'(k);
            if (use_src && !found && st[idx].wee && (st[idx].dest == src)) begin
                r     = stage_code(st[idx].cls, k + 1);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        res_a    = lookup(in_use_a, in_src_a, stage_q);
        res_b    = lookup(in_use_b, in_src_b, stage_q);
        res_c    = lookup(in_use_c, in_src_c, stage_q);
        hazard   = in_valid && (res_a.not_ready || res_b.not_ready || res_c.not_ready);
        issue    = in_valid && !hazard;
        in_ready = issue;
        out_cse  = issue ? in_cse : 8'h00;
        out_addr = issue ? in_dest : '0;
        fwd_a    = issue ? res_a.code : '0;
        fwd_b    = issue ? res_b.code : '0;
        fwd_c    = issue ? res_c.code : '0;
        s1_d.wee  = issue && in_cse[0];
        s1_d.dest = in_dest;
        s1_d.cls  = in_cse[1:2];
    end

    // Shadow pipe never freezes; a stall simply shifts in a non-producing entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q   <= '0;
            stall_cnt <= '0;
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], s1_d};
            if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_even_issue_ctrl.sv
// Bench for even_issue_ctrl: directed vector table, reset/saturation sequences and a
// randomized run against a timestamp-based scoreboard model.
module tb_even_issue_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_cse;
    logic [6:0] in_dest, in_src_a, in_src_b, in_src_c;
    logic       in_use_a, in_use_b, in_use_c;
    logic [0:7] out_cse;
    logic [6:0] out_addr;
    logic [3:0] fwd_a, fwd_b, fwd_c;
    logic       hazard;
    logic [15:0] stall_cnt;

    even_issue_ctrl #(.ADDR_W(7), .DEPTH(7), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_cse(in_cse), .in_dest(in_dest), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_src_c(in_src_c), .in_use_a(in_use_a), .in_use_b(in_use_b), .in_use_c(in_use_c),
        .out_cse(out_cse), .out_addr(out_addr), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: writers remembered with their issue cycle; age = cycles since issue.
    typedef struct { int cyc; logic [6:0] dest; int cls; } wr_t;
    wr_t hist[$];
    int  now;
    int  m_cnt;
    int  code_tab[4][8];
    int  rdy_age[4];

    logic        e_haz, e_rdy;
    logic [3:0]  e_fa, e_fb, e_fc;
    logic [7:0]  e_cse;
    logic [6:0]  e_addr;
    logic [15:0] e_cnt;

    task automatic model_reset();
        hist.delete();
        now   = 0;
        m_cnt = 0;
    endtask

    task automatic src_eval(input logic u, input logic [6:0] s, output bit nr, output logic [3:0] code);
        int best;
        int bcls;
        nr = 1'b0; code = 4'd0; best = 0; bcls = 0;
        if (u) begin
            foreach (hist[i]) begin
                int age;
                age = now - hist[i].cyc;
                if (hist[i].dest == s && age >= 1 && age <= 7 && (best == 0 || age < best)) begin
                    best = age;
                    bcls = hist[i].cls;
                end
            end
            if (best != 0) begin
                if (best < rdy_age[bcls]) nr = 1'b1;
                else code = 4'(code_tab[bcls][best]);
            end
        end
    endtask

    task automatic model_eval();
        bit na, nb, nc;
        logic [3:0] ca, cb, cc;
        src_eval(in_use_a, in_src_a, na, ca);
        src_eval(in_use_b, in_src_b, nb, cb);
        src_eval(in_use_c, in_src_c, nc, cc);
        e_haz  = in_valid && (na || nb || nc);
        e_rdy  = in_valid && !e_haz;
        e_fa   = e_rdy ? ca : 4'd0;
        e_fb   = e_rdy ? cb : 4'd0;
        e_fc   = e_rdy ? cc : 4'd0;
        e_cse  = e_rdy ? 8'(in_cse) : 8'h00;
        e_addr = e_rdy ? in_dest : 7'd0;
        e_cnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    endtask

    task automatic model_adv();
        logic [1:0] c;
        wr_t w;
        c = in_cse[1:2];
        if (e_haz) m_cnt++;
        if (e_rdy && in_cse[0]) begin
            w.cyc = now; w.dest = in_dest; w.cls = int'(c);
            hist.push_back(w);
        end
        now++;
        while (hist.size() > 0 && (now - hist[0].cyc) > 7) void'(hist.pop_front());
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] c, input logic [6:0] d,
                          input logic [6:0] a, input logic [6:0] b, input logic [6:0] cc,
                          input logic ua, input logic ub, input logic uc);
        in_valid = v; in_cse = c; in_dest = d;
        in_src_a = a; in_src_b = b; in_src_c = cc;
        in_use_a = ua; in_use_b = ub; in_use_c = uc;
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic haz,
                             input logic [3:0] fa, input logic [3:0] fb, input logic [3:0] fc,
                             input logic [7:0] cse, input logic [6:0] addr, input logic [15:0] cnt);
        chk($sformatf("%s.in_ready", tag),  32'(in_ready),  32'(rdy));
        chk($sformatf("%s.hazard", tag),    32'(hazard),    32'(haz));
        chk($sformatf("%s.fwd_a", tag),     32'(fwd_a),     32'(fa));
        chk($sformatf("%s.fwd_b", tag),     32'(fwd_b),     32'(fb));
        chk($sformatf("%s.fwd_c", tag),     32'(fwd_c),     32'(fc));
        chk($sformatf("%s.out_cse", tag),   32'(out_cse),   32'(cse));
        chk($sformatf("%s.out_addr", tag),  32'(out_addr),  32'(addr));
        chk($sformatf("%s.stall_cnt", tag), 32'(stall_cnt), 32'(cnt));
    endtask

    task automatic check_model(input string tag);
        model_eval();
        check_all(tag, e_rdy, e_haz, e_fa, e_fb, e_fc, e_cse, e_addr, e_cnt);
    endtask

    typedef struct {
        logic v; logic [7:0] cse; logic [6:0] d, sa, sb, sc; logic ua, ub, uc;
        logic haz; logic [3:0] fa, fb, fc; logic [15:0] cnt;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(input logic v, input logic [7:0] c, input logic [6:0] d,
                                input logic [6:0] sa, input logic [6:0] sb, input logic [6:0] sc,
                                input logic ua, input logic ub, input logic uc, input logic hz,
                                input logic [3:0] fa, input logic [3:0] fb, input logic [3:0] fc,
                                input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.cse = c; r.d = d; r.sa = sa; r.sb = sb; r.sc = sc;
        r.ua = ua; r.ub = ub; r.uc = uc; r.haz = hz; r.fa = fa; r.fb = fb; r.fc = fc; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        bit hold;
        bit seen_fe, seen_ff;
        vec_t v;
        logic r;

        code_tab[0] = '{0, 0, 0, 0, 8, 4, 5, 6};
        code_tab[1] = '{0, 0, 1, 2, 3, 4, 5, 6};
        code_tab[2] = '{0, 0, 0, 0, 7, 4, 5, 6};
        code_tab[3] = '{0, 0, 0, 0, 0, 0, 9, 9};
        rdy_age     = '{4, 2, 4, 6};

        //          v  cse    d   sa  sb  sc ua ub uc hz fa fb fc cnt
        vq.push_back(mk(1, 8'hA0,  5,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 8'h01, 10,  5,  0,  0, 1, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 8'h01, 10,  5,  0,  0, 1, 0, 0, 0, 1, 0, 0, 1));
        vq.push_back(mk(1, 8'h80,  9,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 8'h01, 11,  0,  9,  9, 0, 1, 1, 1, 0, 0, 0, 1));
        vq.push_back(mk(1, 8'h01, 11,  0,  9,  9, 0, 1, 1, 1, 0, 0, 0, 2));
        vq.push_back(mk(1, 8'h01, 11,  0,  9,  9, 0, 1, 1, 1, 0, 0, 0, 3));
        vq.push_back(mk(1, 8'h01, 11,  0,  9,  9, 0, 1, 1, 0, 0, 8, 8, 4));
        vq.push_back(mk(1, 8'hE0,  3,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 4));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(1, 8'h01, 12, 3, 0, 0, 1, 0, 0, 1, 0, 0, 0, 16'(4 + i)));
        vq.push_back(mk(1, 8'h01, 12,  3,  0,  0, 1, 0, 0, 0, 9, 0, 0, 9));
        vq.push_back(mk(0, 8'h00,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 9));
        vq.push_back(mk(1, 8'h01, 12,  3,  0,  0, 1, 0, 0, 0, 0, 0, 0, 9));
        vq.push_back(mk(1, 8'hC0,  4,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 9));
        vq.push_back(mk(1, 8'hA0,  4,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 9));
        vq.push_back(mk(1, 8'h01,  0,  4,  0,  0, 1, 0, 0, 1, 0, 0, 0, 9));
        vq.push_back(mk(1, 8'h01,  0,  4,  0,  0, 1, 0, 0, 0, 1, 0, 0, 10));
        vq.push_back(mk(1, 8'hA0,  6,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 10));
        vq.push_back(mk(1, 8'h20,  7,  6,  0,  0, 0, 0, 0, 0, 0, 0, 0, 10));
        vq.push_back(mk(1, 8'h01,  0,  6,  7,  0, 1, 1, 0, 0, 1, 0, 0, 10));
        vq.push_back(mk(1, 8'hA0, 12, 12,  0,  5, 1, 0, 1, 0, 0, 0, 0, 10));

        reset = 1'b1;
        set_in(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_all("reset", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vq[i]) begin
            v = vq[i];
            set_in(v.v, v.cse, v.d, v.sa, v.sb, v.sc, v.ua, v.ub, v.uc);
            #2;
            model_eval();
            r = v.v && !v.haz;
            check_all($sformatf("vec%0d", i), r, v.haz, v.fa, v.fb, v.fc,
                      r ? v.cse : 8'h00, r ? v.d : 7'd0, v.cnt);
            next_cycle();
        end

        // Byte producer, consumer stalls, async reset mid-stall.
        set_in(1, 8'h80, 9, 0, 0, 0, 0, 0, 0);
        #2; check_model("rst_prod");
        next_cycle();
        set_in(1, 8'h01, 1, 0, 9, 0, 0, 1, 0);
        #2; check_model("rst_stall");
        chk("rst_stall_haz", 32'(hazard), 32'd1);
        next_cycle();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_model("rst_async");
        chk("rst_async_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check_model("rst_first");
        chk("rst_first_ready", 32'(in_ready), 32'd1);
        chk("rst_first_fwd_b", 32'(fwd_b), 32'd0);
        next_cycle();

        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                set_in(($urandom_range(0, 7) != 0), 8'($urandom), 7'($urandom_range(0, 7)),
                       7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                       1'($urandom), 1'($urandom), 1'($urandom));
            end
            #2;
            check_model($sformatf("rnd%0d", i));
            hold = e_haz;
            next_cycle();
        end

        // Saturation: FP op reading its own destination yields 5 hazard cycles per issue.
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(1, 8'hE0, 3, 3, 0, 0, 1, 0, 0);
        seen_fe = 1'b0;
        seen_ff = 1'b0;
        for (int i = 0; i < 80000 && m_cnt < 65539; i++) begin
            #2;
            model_eval();
            if (m_cnt == 65534 && !seen_fe) begin
                seen_fe = 1'b1;
                chk("sat_fffe", 32'(stall_cnt), 32'(e_cnt));
            end
            if (m_cnt == 65535 && !seen_ff) begin
                seen_ff = 1'b1;
                chk("sat_ffff", 32'(stall_cnt), 32'(e_cnt));
            end
            @(posedge clk);
            model_adv();
            #1;
        end
        #2;
        check_model("sat_end");
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
